// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready bundle for the pipelined barrel shifter.
// Carries the operand side and the result side of one shift/rotate op.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one 2^k shift stage per count bit,
// registered after every stage, valid/ready with full backpressure.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  pipelined_barrel_shifter_if.slave bus
);

  localparam logic [1:0] ROTL = 2'b00;
  localparam logic [1:0] SLL  = 2'b01;
  localparam logic [1:0] ROTR = 2'b10;
  localparam logic [1:0] SRL  = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;
    logic             carry;
  } stage_t;

  logic [CNT_W-1:0] vld;
  logic [CNT_W-1:0] adv;
  stage_t           st [CNT_W];

  // A stage may move when it is empty or its successor moves.
  always_comb begin
    logic a;
    a = !vld[CNT_W-1] | bus.out_ready;
    adv[CNT_W-1] = a;
    for (int k = CNT_W - 2; k >= 0; k--) begin
      a = !vld[k] | a;
      adv[k] = a;
    end
  end

  for (genvar k = 0; k < CNT_W; k++) begin : g_stg
    localparam int SH = 1 << k;

    stage_t src;
    stage_t nxt;
    stage_t s_q;
    logic   src_v;
    logic   v_q;

    if (k == 0) begin : g_head
      assign src_v = bus.in_valid;
      assign src   = {bus.in_data, bus.in_cnt, bus.in_op, 1'b0};
    end else begin : g_body
      assign src_v = vld[k-1];
      assign src   = st[k-1];
    end

    always_comb begin
      nxt = src;
      if (src.cnt[k]) begin
        unique case (src.op)
          ROTL: begin
            nxt.data  = (src.data << SH) | (src.data >> (WIDTH - SH));
            nxt.carry = src.data[WIDTH-SH];
          end
          SLL: begin
            nxt.data  = src.data << SH;
            nxt.carry = src.data[WIDTH-SH];
          end
          ROTR: begin
            nxt.data  = (src.data >> SH) | (src.data << (WIDTH - SH));
            nxt.carry = src.data[SH-1];
          end
          SRL: begin
            nxt.data  = src.data >> SH;
            nxt.carry = src.data[SH-1];
          end
          default: nxt = src;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (adv[k]) begin
        v_q <= src_v;
        if (src_v) s_q <= nxt;
      end
    end

    assign vld[k] = v_q;
    assign st[k]  = s_q;
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld[CNT_W-1];
  assign bus.out_data  = st[CNT_W-1].data;
  assign bus.out_carry = st[CNT_W-1].carry;
  // Gated so the flag reads 0 out of reset and on bubbles.
  assign bus.out_zero  = vld[CNT_W-1] & ~|st[CNT_W-1].data;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed cases plus random
// traffic against a whole-count shift/rotate reference model.
module tb_pipelined_barrel_shifter;
  localparam int W  = 16;
  localparam int CW = 4;

  localparam logic [1:0] ROTL = 2'b00;
  localparam logic [1:0] SLL  = 2'b01;
  localparam logic [1:0] ROTR = 2'b10;
  localparam logic [1:0] SRL  = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  pipelined_barrel_shifter_if #(.WIDTH(W)) bus ();

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: shift/rotate by the full count in one step.
  function automatic logic [W:0] model(logic [W-1:0] d, int n, logic [1:0] op);
    logic [W-1:0] r;
    logic         c;
    if (n == 0) return {1'b0, d};
    case (op)
      ROTL:    begin r = (d << n) | (d >> (W - n)); c = d[W-n]; end
      SLL:     begin r = d << n;                    c = d[W-n]; end
      ROTR:    begin r = (d >> n) | (d << (W - n)); c = d[n-1]; end
      default: begin r = d >> n;                    c = d[n-1]; end
    endcase
    return {c, r};
  endfunction

  logic [W:0] q [$];
  int         rel_cnt = 0;
  logic       hold_v  = 1'b0;
  logic [W-1:0] hold_d;
  logic       hold_c;

  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst_n) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v && bus.out_valid) begin
        chk("hold_data", 32'(bus.out_data), 32'(hold_d));
        chk("hold_carry", 32'(bus.out_carry), 32'(hold_c));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          rel_cnt++;
          if (q.size() == 0) begin
            chk("spurious_out", 32'(1), 32'(0));
          end else begin
            e = q.pop_front();
            chk("sb_data", 32'(bus.out_data), 32'(e[W-1:0]));
            chk("sb_carry", 32'(bus.out_carry), 32'(e[W]));
            chk("sb_zero", 32'(bus.out_zero), 32'(e[W-1:0] == '0));
          end
        end
        if (bus.in_valid && bus.in_ready)
          q.push_back(model(bus.in_data, int'(bus.in_cnt), bus.in_op));
      end
      hold_v = bus.out_valid && !bus.out_ready && !flush;
      hold_d = bus.out_data;
      hold_c = bus.out_carry;
    end
  end

  task automatic drive(logic [W-1:0] d, logic [CW-1:0] c, logic [1:0] op);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_cnt   = c;
    bus.in_op    = op;
  endtask

  task automatic run_one(logic [W-1:0] d, logic [CW-1:0] c, logic [1:0] op,
                         logic [W-1:0] ed, logic ec, logic ez);
    int lat;
    drive(d, c, op);
    @(negedge clk);
    chk("one_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("one_latency", 32'(lat), 32'(4));
    chk("one_data", 32'(bus.out_data), 32'(ed));
    chk("one_carry", 32'(bus.out_carry), 32'(ec));
    chk("one_zero", 32'(bus.out_zero), 32'(ez));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    while ((q.size() != 0 || bus.out_valid) && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_left", 32'(q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int cnt;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cnt    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_data", 32'(bus.out_data), 32'(0));
    chk("rst_carry", 32'(bus.out_carry), 32'(0));
    chk("rst_zero", 32'(bus.out_zero), 32'(0));
    chk("rst_ready", 32'(bus.in_ready), 32'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one(16'h8001, 4'd1,  ROTL, 16'h0003, 1'b1, 1'b0);
    run_one(16'h8001, 4'd4,  SLL,  16'h0010, 1'b0, 1'b0);
    run_one(16'hF000, 4'd15, SRL,  16'h0001, 1'b1, 1'b0);
    run_one(16'h0001, 4'd1,  ROTR, 16'h8000, 1'b1, 1'b0);
    run_one(16'h0001, 4'd1,  SRL,  16'h0000, 1'b1, 1'b1);
    for (int o = 0; o < 4; o++)
      run_one(16'h1234, 4'd0, 2'(o), 16'h1234, 1'b0, 1'b0);
    drain();

    // Back-to-back stream with no backpressure.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive(W'($urandom), CW'($urandom), 2'($urandom));
          @(negedge clk);
          chk("t4_ready", 32'(bus.in_ready), 32'(1));
          @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
      end
      begin
        int w = 0;
        int run;
        do begin
          @(negedge clk);
          w++;
        end while (!bus.out_valid && w < 20);
        run = 1;
        for (int j = 1; j < 8; j++) begin
          @(negedge clk);
          if (bus.out_valid) run++;
        end
        chk("t4_burst", 32'(run), 32'(8));
      end
    join
    drain();

    // Stall output for six cycles while streaming.
    bus.out_ready = 1'b0;
    acc = 0;
    drive(W'($urandom), CW'($urandom), 2'($urandom));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
      if (acc > 0 && acc == i + 1)
        drive(W'($urandom), CW'($urandom), 2'($urandom));
    end
    chk("t5_accepted", 32'(acc), 32'(4));
    chk("t5_ready_low", 32'(bus.in_ready), 32'(0));
    bus.out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 4; i++) begin
      @(negedge clk);
      if (bus.in_ready) cnt++;
      @(posedge clk); #1;
      drive(W'($urandom), CW'($urandom), 2'($urandom));
    end
    chk("t5_resume", 32'(cnt), 32'(4));
    drain();

    // Flush with three ops in flight and a same-cycle input.
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom), CW'($urandom), 2'($urandom));
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'(0));
    chk("flush_ready", 32'(bus.in_ready), 32'(1));
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("flush_stale", 32'(cnt), 32'(0));

    // Asynchronous reset with three ops in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom), CW'($urandom), 2'($urandom));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("arst_stale", 32'(cnt), 32'(0));
    @(posedge clk); #1;

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.in_data   = ($urandom_range(7) == 0) ? W'(1 << $urandom_range(W-1))
                                               : W'($urandom);
      bus.in_cnt    = CW'($urandom);
      bus.in_op     = 2'($urandom);
      bus.out_ready = ($urandom_range(2) != 0);
      flush         = ($urandom_range(59) == 0);
      @(posedge clk); #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
